// File: rtl/impl_ram_stream_loader.sv
// Loads a length-framed, checksummed byte stream into program RAM as little-endian
// 32-bit words and reports a verified (done) or rejected (error) load.
module impl_ram_stream_loader #(
  parameter int unsigned                ADDR_WIDTH = 22,
  parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR  = '0,
  parameter int unsigned                MAX_BYTES  = 131072
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int unsigned CNT_W   = $clog2(MAX_BYTES + 1);
  localparam logic [31:0] MAX_LEN = 32'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t           state;
  logic [1:0]       len_idx;
  logic [31:0]      len;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       sum;
  logic [31:0]      wbuf;

  logic             xfer_c;
  logic [1:0]       lane_c;
  logic [31:0]      len_next_c;
  logic [31:0]      word_c;
  logic             last_c;
  logic [3:0]       be_c;

  // Datapath helpers for the byte currently offered on the stream
  always_comb begin
    xfer_c     = byte_valid_i & byte_ready_o;
    lane_c     = cnt[1:0];
    len_next_c = {byte_data_i, len[31:8]};
    word_c     = wbuf | ({24'd0, byte_data_i} << {lane_c, 3'b000});
    last_c     = ((32'(cnt) + 32'd1) == len);
    be_c       = {lane_c == 2'd3, lane_c >= 2'd2, lane_c >= 2'd1, 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      len_idx      <= '0;
      len          <= '0;
      cnt          <= '0;
      sum          <= '0;
      wbuf         <= '0;
      byte_ready_o <= 1'b0;
      mem_en_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_be_o     <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      mem_en_o <= 1'b0;
      mem_we_o <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state        <= S_LEN;
            len_idx      <= '0;
            len          <= '0;
            cnt          <= '0;
            sum          <= '0;
            wbuf         <= '0;
            byte_ready_o <= 1'b1;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
          end
        end
        S_LEN: begin
          if (xfer_c) begin
            len     <= len_next_c;
            len_idx <= len_idx + 2'd1;
            if (len_idx == 2'd3) begin
              if (len_next_c > MAX_LEN) begin
                state        <= S_ERR;
                byte_ready_o <= 1'b0;
                busy_o       <= 1'b0;
                error_o      <= 1'b1;
              end else if (len_next_c == 32'd0) begin
                state <= S_CHK;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (xfer_c) begin
            cnt <= cnt + CNT_W'(1);
            sum <= sum + byte_data_i;
            // Emit a word when its top lane fills or the payload ends early
            if (lane_c == 2'd3 || last_c) begin
              mem_en_o    <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= BASE_ADDR + ADDR_WIDTH'({cnt[CNT_W-1:2], 2'b00});
              mem_wdata_o <= word_c;
              mem_be_o    <= be_c;
              wbuf        <= '0;
            end else begin
              wbuf <= word_c;
            end
            if (last_c) state <= S_CHK;
          end
        end
        S_CHK: begin
          if (xfer_c) begin
            byte_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            if (byte_data_i == sum) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              state   <= S_ERR;
              error_o <= 1'b1;
            end
          end
        end
        default: begin
          state        <= S_IDLE;
          byte_ready_o <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule
